regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The module SHALL have parameter NREG, default 16, meaning the number of 32-bit architectural registers (fixed power of two).
REQ-002 The module SHALL have parameter AW, default 4, meaning the register address width, log2(NREG).
REQ-003 The module SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset  input  1  meaning an asynchronous, active-low reset.
REQ-005 The module SHALL have port a_req  input  1  meaning the requester A (ALU writeback) write request.
REQ-006 The module SHALL have port a_addr  input  AW  meaning the requester A target register.
REQ-007 The module SHALL have port a_data  input  32  meaning the requester A write data.
REQ-008 The module SHALL have port a_gnt  output  1  meaning requester A is granted the write this cycle.
REQ-009 The module SHALL have ports b_req, b_addr, b_data and b_gnt, identical to the A ports, for requester B (load writeback).
REQ-010 The module SHALL have ports rd0_addr and rd1_addr  input  AW  meaning the read port addresses.
REQ-011 The module SHALL have ports rd0_data and rd1_data  output  32  meaning the read port data.
REQ-012 The module SHALL have port conflict_cnt  output  8  meaning a saturating count of contended cycles.

Function
REQ-013 Storage SHALL be NREG x 32-bit registers; each register is written only on a rising clk edge while its write is granted.
REQ-014 Grants SHALL be combinational in the request cycle; the write commits at the rising edge that ends that cycle.
REQ-015 At most one of a_gnt and b_gnt SHALL be high in any cycle.
REQ-016 A gnt SHALL never be high unless the matching req is high.
REQ-017 With only one req high, that requester SHALL be granted.
REQ-018 With both req high, grant SHALL follow round-robin on a one-bit state last_gnt (LAST_A or LAST_B); the requester not granted last wins.
REQ-019 last_gnt SHALL update on every edge where a grant occurred, and SHALL hold on idle cycles.
REQ-020 The losing requester SHALL hold req, addr and data stable until granted; it is granted on the next cycle, so the maximum wait is 1 cycle.
REQ-021 A requester SHALL be allowed to deassert req before being granted; no write occurs for it.
REQ-022 When both requesters target the same address, only the granted data SHALL be written in that cycle; the loser writes the next cycle, leaving the loser's data as the final value.
REQ-023 Reads SHALL have 0-cycle latency: rdN_data = reg[rdN_addr] combinationally.
REQ-024 Bypass: if a write is granted this cycle to rdN_addr, rdN_data SHALL equal that write's data instead of the stored value.
REQ-025 Both read ports SHALL be independent and SHALL be allowed to address the same register.
REQ-026 conflict_cnt SHALL increment by 1 on each edge where a_req and b_req were both high, and SHALL saturate at 8'hFF with no wrap.
REQ-027 Out-of-range addresses SHALL NOT occur, because AW equals log2(NREG).

Reset
REQ-028 While reset is low, all registers SHALL read 32'h00000000 and conflict_cnt SHALL be 0, asynchronously.
REQ-029 While reset is low, last_gnt SHALL be LAST_B, so A wins the first contention after reset.
REQ-030 While reset is low, a_gnt and b_gnt SHALL be 0 regardless of req, and no write SHALL commit.
REQ-031 Reset asserted mid-operation SHALL discard any in-flight grant; operation resumes from the reset state on the first edge after reset rises.

Verification
REQ-032 The bench SHALL cover: after reset, a_req=1, a_addr=3, a_data=32'hDEADBEEF for one cycle -> a_gnt=1 that cycle; next cycle rd0_addr=3 reads 32'hDEADBEEF.
REQ-033 The bench SHALL cover: both req high, a_addr=1, b_addr=2, held -> cycle 0 a_gnt=1; cycle 1 b_gnt=1; both values stored; conflict_cnt=1.
REQ-034 The bench SHALL cover: both req, same addr 5, a_data=32'h11, b_data=32'h22 -> A writes first, then B; reg5=32'h22.
REQ-035 The bench SHALL cover bypass: b_req, b_addr=7, b_data=32'hCAFE0000, rd1_addr=7 in the same cycle -> rd1_data=32'hCAFE0000 in that cycle.
REQ-036 The bench SHALL cover: 300 consecutive contended cycles -> conflict_cnt reaches 8'hFF and stays there; grants alternate A,B,A,B.
REQ-037 The bench SHALL cover: reset pulsed low mid-stream with a_req high -> gnt=0, all reads 0, conflict_cnt=0 immediately; first contention afterwards grants A.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Two-requester write arbiter in front of a NREG x 32 register file with two
// bypassed combinational read ports and a saturating contention counter.
module regfile_write_arbiter #(
   parameter int NREG = 16,
   parameter int AW   = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          a_req,
   input  logic [AW-1:0] a_addr,
   input  logic [31:0]   a_data,
   output logic          a_gnt,
   input  logic          b_req,
   input  logic [AW-1:0] b_addr,
   input  logic [31:0]   b_data,
   output logic          b_gnt,
   input  logic [AW-1:0] rd0_addr,
   input  logic [AW-1:0] rd1_addr,
   output logic [31:0]   rd0_data,
   output logic [31:0]   rd1_data,
   output logic [7:0]    conflict_cnt
);

   typedef enum logic {
      LAST_A = 1'b0,
      LAST_B = 1'b1
   } last_gnt_t;

   last_gnt_t     r_last_gnt;
   logic [31:0]   r_regs [NREG];
   logic [7:0]    r_conflict_cnt;

   logic          w_contend;
   logic          w_a_gnt;
   logic          w_b_gnt;
   logic          w_wr_en;
   logic [AW-1:0] w_wr_addr;
   logic [31:0]   w_wr_data;

   assign w_contend = a_req & b_req;

   // Grants are forced low while reset is held so nothing can commit.
   always_comb begin
      w_a_gnt   = 1'b0;
      w_b_gnt   = 1'b0;
      w_wr_en   = 1'b0;
      w_wr_addr = '0;
      w_wr_data = '0;
      if (reset) begin
         if (w_contend) begin
            w_a_gnt = (r_last_gnt == LAST_B);
            w_b_gnt = (r_last_gnt == LAST_A);
         end else begin
            w_a_gnt = a_req;
            w_b_gnt = b_req;
         end
      end
      if (w_a_gnt) begin
         w_wr_en   = 1'b1;
         w_wr_addr = a_addr;
         w_wr_data = a_data;
      end else if (w_b_gnt) begin
         w_wr_en   = 1'b1;
         w_wr_addr = b_addr;
         w_wr_data = b_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_last_gnt <= LAST_B;
      end else if (w_a_gnt) begin
         r_last_gnt <= LAST_A;
      end else if (w_b_gnt) begin
         r_last_gnt <= LAST_B;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_conflict_cnt <= '0;
      end else if (w_contend && (r_conflict_cnt != 8'hFF)) begin
         r_conflict_cnt <= r_conflict_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wr_en) begin
         r_regs[w_wr_addr] <= w_wr_data;
      end
   end

   // A write granted this cycle is forwarded to any read port addressing it.
   always_comb begin
      rd0_data = r_regs[rd0_addr];
      rd1_data = r_regs[rd1_addr];
      if (w_wr_en && (w_wr_addr == rd0_addr)) begin
         rd0_data = w_wr_data;
      end
      if (w_wr_en && (w_wr_addr == rd1_addr)) begin
         rd1_data = w_wr_data;
      end
   end

   assign a_gnt        = w_a_gnt;
   assign b_gnt        = w_b_gnt;
   assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed testbench for regfile_write_arbiter: arbitration, bypass,
// saturation and asynchronous reset behaviour.
module tb_regfile_write_arbiter;

   logic        clk;
   logic        reset;
   logic        a_req, b_req;
   logic [3:0]  a_addr, b_addr;
   logic [31:0] a_data, b_data;
   logic        a_gnt, b_gnt;
   logic [3:0]  rd0_addr, rd1_addr;
   logic [31:0] rd0_data, rd1_data;
   logic [7:0]  conflict_cnt;

   int n_pass;
   int n_total;

   regfile_write_arbiter #(.NREG(16), .AW(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .a_req        (a_req),
      .a_addr       (a_addr),
      .a_data       (a_data),
      .a_gnt        (a_gnt),
      .b_req        (b_req),
      .b_addr       (b_addr),
      .b_data       (b_data),
      .b_gnt        (b_gnt),
      .rd0_addr     (rd0_addr),
      .rd1_addr     (rd1_addr),
      .rd0_data     (rd0_data),
      .rd1_data     (rd1_data),
      .conflict_cnt (conflict_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle_inputs();
      a_req = 1'b0; a_addr = '0; a_data = '0;
      b_req = 1'b0; b_addr = '0; b_data = '0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      idle_inputs();
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b0;
      a_req = 1'b1; b_req = 1'b1; a_addr = 4'd3; b_addr = 4'd4;
      a_data = 32'h12345678; b_data = 32'h9ABCDEF0;
      rd0_addr = 4'd3; rd1_addr = 4'd4;
      #1;
      n_total++;
      if ({a_gnt, b_gnt} !== 2'b00) $display("FAIL reset_gnt got %b exp 00", {a_gnt, b_gnt});
      else n_pass++;
      @(negedge clk);
      #1;
      n_total++;
      if (conflict_cnt !== 8'h00) $display("FAIL reset_cnt got %h exp 00", conflict_cnt);
      else n_pass++;
      n_total++;
      if (rd0_data !== 32'h0 || rd1_data !== 32'h0)
         $display("FAIL reset_read got %h/%h exp 0/0", rd0_data, rd1_data);
      else n_pass++;
      @(negedge clk);
      idle_inputs();
      reset = 1'b1;
   endtask

   task automatic test_single_write();
      @(negedge clk);
      a_req = 1'b1; a_addr = 4'd3; a_data = 32'hDEADBEEF;
      rd0_addr = 4'd3;
      #1;
      n_total++;
      if ({a_gnt, b_gnt} !== 2'b10) $display("FAIL single_gnt got %b exp 10", {a_gnt, b_gnt});
      else n_pass++;
      @(negedge clk);
      idle_inputs();
      rd0_addr = 4'd3;
      #1;
      n_total++;
      if (rd0_data !== 32'hDEADBEEF) $display("FAIL single_read got %h exp DEADBEEF", rd0_data);
      else n_pass++;
      n_total++;
      if (conflict_cnt !== 8'h00) $display("FAIL single_cnt got %h exp 00", conflict_cnt);
      else n_pass++;
   endtask

   task automatic test_contention();
      apply_reset();
      @(negedge clk);
      a_req = 1'b1; a_addr = 4'd1; a_data = 32'h11110001;
      b_req = 1'b1; b_addr = 4'd2; b_data = 32'h22220002;
      #1;
      n_total++;
      if ({a_gnt, b_gnt} !== 2'b10) $display("FAIL contend_c0 got %b exp 10", {a_gnt, b_gnt});
      else n_pass++;
      @(negedge clk);
      a_req = 1'b0;
      #1;
      n_total++;
      if ({a_gnt, b_gnt} !== 2'b01) $display("FAIL contend_c1 got %b exp 01", {a_gnt, b_gnt});
      else n_pass++;
      @(negedge clk);
      idle_inputs();
      rd0_addr = 4'd1; rd1_addr = 4'd2;
      #1;
      n_total++;
      if (rd0_data !== 32'h11110001 || rd1_data !== 32'h22220002)
         $display("FAIL contend_store got %h/%h exp 11110001/22220002", rd0_data, rd1_data);
      else n_pass++;
      n_total++;
      if (conflict_cnt !== 8'h01) $display("FAIL contend_cnt got %h exp 01", conflict_cnt);
      else n_pass++;
   endtask

   task automatic test_same_addr();
      @(negedge clk);
      a_req = 1'b1; a_addr = 4'd5; a_data = 32'h11;
      b_req = 1'b1; b_addr = 4'd5; b_data = 32'h22;
      rd0_addr = 4'd5;
      #1;
      n_total++;
      if ({a_gnt, b_gnt} !== 2'b10 || rd0_data !== 32'h11)
         $display("FAIL same_c0 got gnt=%b rd=%h exp gnt=10 rd=11", {a_gnt, b_gnt}, rd0_data);
      else n_pass++;
      @(negedge clk);
      a_req = 1'b0;
      #1;
      n_total++;
      if ({a_gnt, b_gnt} !== 2'b01 || rd0_data !== 32'h22)
         $display("FAIL same_c1 got gnt=%b rd=%h exp gnt=01 rd=22", {a_gnt, b_gnt}, rd0_data);
      else n_pass++;
      @(negedge clk);
      idle_inputs();
      rd0_addr = 4'd5; rd1_addr = 4'd5;
      #1;
      n_total++;
      if (rd0_data !== 32'h22 || rd1_data !== 32'h22)
         $display("FAIL same_final got %h/%h exp 22/22", rd0_data, rd1_data);
      else n_pass++;
      n_total++;
      if (conflict_cnt !== 8'h02) $display("FAIL same_cnt got %h exp 02", conflict_cnt);
      else n_pass++;
   endtask

   task automatic test_bypass();
      @(negedge clk);
      b_req = 1'b1; b_addr = 4'd7; b_data = 32'hCAFE0000;
      rd0_addr = 4'd2; rd1_addr = 4'd7;
      #1;
      n_total++;
      if (b_gnt !== 1'b1 || rd1_data !== 32'hCAFE0000)
         $display("FAIL bypass_same got gnt=%b rd1=%h exp gnt=1 rd1=CAFE0000", b_gnt, rd1_data);
      else n_pass++;
      n_total++;
      if (rd0_data !== 32'h22220002) $display("FAIL bypass_other got %h exp 22220002", rd0_data);
      else n_pass++;
      @(negedge clk);
      idle_inputs();
      #1;
      n_total++;
      if (rd1_data !== 32'hCAFE0000) $display("FAIL bypass_stored got %h exp CAFE0000", rd1_data);
      else n_pass++;
   endtask

   task automatic test_saturation();
      logic exp_a;
      int   exp_cnt;
      exp_a   = 1'b1;
      exp_cnt = 2;
      @(negedge clk);
      a_req = 1'b1; a_addr = 4'd8; a_data = 32'hAAAA0008;
      b_req = 1'b1; b_addr = 4'd9; b_data = 32'hBBBB0009;
      for (int i = 0; i < 300; i++) begin
         #1;
         n_total++;
         if ({a_gnt, b_gnt} !== {exp_a, ~exp_a})
            $display("FAIL sat_gnt[%0d] got %b exp %b", i, {a_gnt, b_gnt}, {exp_a, ~exp_a});
         else n_pass++;
         n_total++;
         if (conflict_cnt !== exp_cnt[7:0])
            $display("FAIL sat_cnt[%0d] got %h exp %h", i, conflict_cnt, exp_cnt[7:0]);
         else n_pass++;
         @(negedge clk);
         exp_a = ~exp_a;
         if (exp_cnt < 255) exp_cnt++;
      end
      idle_inputs();
      #1;
      n_total++;
      if (conflict_cnt !== 8'hFF) $display("FAIL sat_final got %h exp FF", conflict_cnt);
      else n_pass++;
      @(negedge clk);
      #1;
      n_total++;
      if (conflict_cnt !== 8'hFF) $display("FAIL sat_hold got %h exp FF", conflict_cnt);
      else n_pass++;
   endtask

   task automatic test_reset_midstream();
      // Leave last grant on A so a post-reset A win proves the reset state.
      @(negedge clk);
      a_req = 1'b1; a_addr = 4'd10; a_data = 32'h0000000A;
      @(negedge clk);
      a_req = 1'b1; a_addr = 4'd8; a_data = 32'h01234567;
      b_req = 1'b1; b_addr = 4'd9; b_data = 32'h89ABCDEF;
      rd0_addr = 4'd7; rd1_addr = 4'd10;
      #1;
      reset = 1'b0;
      #1;
      n_total++;
      if ({a_gnt, b_gnt} !== 2'b00) $display("FAIL mid_gnt got %b exp 00", {a_gnt, b_gnt});
      else n_pass++;
      n_total++;
      if (rd0_data !== 32'h0 || rd1_data !== 32'h0)
         $display("FAIL mid_read got %h/%h exp 0/0", rd0_data, rd1_data);
      else n_pass++;
      n_total++;
      if (conflict_cnt !== 8'h00) $display("FAIL mid_cnt got %h exp 00", conflict_cnt);
      else n_pass++;
      @(negedge clk);
      reset = 1'b1;
      #1;
      n_total++;
      if ({a_gnt, b_gnt} !== 2'b10) $display("FAIL mid_first got %b exp 10", {a_gnt, b_gnt});
      else n_pass++;
      @(negedge clk);
      idle_inputs();
      rd0_addr = 4'd8; rd1_addr = 4'd9;
      #1;
      n_total++;
      if (conflict_cnt !== 8'h01 || rd0_data !== 32'h01234567 || rd1_data !== 32'h0)
         $display("FAIL mid_after got cnt=%h rd=%h/%h exp cnt=01 rd=01234567/00000000",
                  conflict_cnt, rd0_data, rd1_data);
      else n_pass++;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      reset   = 1'b0;
      rd0_addr = '0;
      rd1_addr = '0;
      idle_inputs();
      test_reset();
      test_single_write();
      test_contention();
      test_same_addr();
      test_bypass();
      test_saturation();
      test_reset_midstream();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
